// File: rtl/otter_intrpt_ctrl_if.sv
// ---------------------------------------------------------------------------
// otter_intrpt_ctrl_if
// Purpose : bundles the memory-mapped register port and the control-unit
//           interrupt handshake of otter_intrpt_ctrl into one interface.
// Signals :
//   reg_sel      register port selected this cycle
//   reg_we       1 = write, 0 = read (qualified by reg_sel)
//   reg_addr     word index of register
//   reg_wdata    write data
//   reg_rdata    registered read data
//   intrpt_taken CU pulse: interrupt entered
//   intrpt_vld   interrupt request level to the CU
//   intrpt_cause index of the claimed/requested source
//   intrpt_busy  handler active
// Modports: master = bus master / CU side, slave = interrupt controller.
// ---------------------------------------------------------------------------
interface otter_intrpt_ctrl_if;
    logic        reg_sel;
    logic        reg_we;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        intrpt_taken;
    logic        intrpt_vld;
    logic [4:0]  intrpt_cause;
    logic        intrpt_busy;

    modport master (
        output reg_sel, reg_we, reg_addr, reg_wdata, intrpt_taken,
        input  reg_rdata, intrpt_vld, intrpt_cause, intrpt_busy
    );

    modport slave (
        input  reg_sel, reg_we, reg_addr, reg_wdata, intrpt_taken,
        output reg_rdata, intrpt_vld, intrpt_cause, intrpt_busy
    );
endinterface

// File: rtl/otter_intrpt_ctrl.sv
// ---------------------------------------------------------------------------
// otter_intrpt_ctrl
// Purpose : interrupt controller in front of the OTTER control-unit FSM.
//           Synchronizes NUM_SRC raw interrupt lines, latches rising edges as
//           pending, masks them with ENABLE and presents the lowest-index
//           active source to the CU. The request is held until the CU
//           returns intrpt_taken; further requests are blocked until software
//           writes CLAIM (end-of-interrupt).
// Ports   :
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_irq_src  raw asynchronous interrupt lines, rising-edge sensitive
//   bus        otter_intrpt_ctrl_if.slave (register port + CU handshake)
// Registers (reg_addr): 0 PENDING (R/W1C), 1 ENABLE (RW), 2 CLAIM (R cause,
//   W = EOI), 3 STATUS (R {GIE,busy}, W bit1 = GIE), 4 MTIME, 5 MTIMECMP.
// Optional: define INTC_TIMER_EN to add the MTIME/MTIMECMP timer as source
//   index NUM_SRC (lowest priority). Without it addresses 4/5 read 0.
// ---------------------------------------------------------------------------
module otter_intrpt_ctrl #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_SRC-1:0]   i_irq_src,
    otter_intrpt_ctrl_if.slave   bus
);

`ifdef INTC_TIMER_EN
    localparam int NB = NUM_SRC + 1;
`else
    localparam int NB = NUM_SRC;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_vld;
    logic               r_busy;
    logic [4:0]         r_cause;
    logic               r_gie;
    logic [NB-1:0]      r_pend;
    logic [NB-1:0]      r_en;
    logic [31:0]        r_rdata;
    logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
    logic [NUM_SRC-1:0] r_prev;

    logic               w_wr;
    logic               w_rd;
    logic               w_eoi;
    logic               w_claim;
    logic [NUM_SRC-1:0] w_rise;
    logic [NB-1:0]      w_set;
    logic [NB-1:0]      w_w1c;
    logic [NB-1:0]      w_claim_clr;
    logic [NB-1:0]      w_act;
    logic [4:0]         w_win;
    logic [31:0]        w_rd_mux;
    logic               w_unused_wdata;

    assign w_wr    = bus.reg_sel &&  bus.reg_we;
    assign w_rd    = bus.reg_sel && !bus.reg_we;
    assign w_eoi   = w_wr && (bus.reg_addr == 3'd2);
    assign w_claim = (r_state == ST_REQ) && bus.intrpt_taken;

    // Upper write-data bits are architecturally ignored for narrow registers.
    assign w_unused_wdata = ^bus.reg_wdata[31:NB];

    // Multi-flop synchronizer, then one more flop for rising-edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_irq_src;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

`ifdef INTC_TIMER_EN
    logic [31:0] r_mtime;
    logic [31:0] r_mtimecmp;
    logic        w_timer_hit;

    // A software write to MTIME overrides the free-running increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mtime    <= '0;
            r_mtimecmp <= 32'hFFFF_FFFF;
        end else begin
            if (w_wr && bus.reg_addr == 3'd4) r_mtime <= bus.reg_wdata;
            else                              r_mtime <= r_mtime + 32'd1;
            if (w_wr && bus.reg_addr == 3'd5) r_mtimecmp <= bus.reg_wdata;
        end
    end

    assign w_timer_hit = (r_mtime == r_mtimecmp);
    assign w_set       = {w_timer_hit, w_rise};
`else
    assign w_set       = w_rise;
`endif

    assign w_w1c       = (w_wr && bus.reg_addr == 3'd0) ? bus.reg_wdata[NB-1:0] : '0;
    assign w_claim_clr = w_claim ? ({{(NB-1){1'b0}}, 1'b1} << r_cause) : '0;
    assign w_act       = r_pend & r_en;

    // Fixed priority: lowest set index wins, so scan from the top down.
    always_comb begin
        w_win = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (w_act[i]) w_win = 5'(i);
        end
    end

    // New edges are OR-ed in last so they survive a W1C or claim-clear
    // of the same bit in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= '0;
            r_en   <= '0;
            r_gie  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_w1c & ~w_claim_clr) | w_set;
            if (w_wr && bus.reg_addr == 3'd1) r_en  <= bus.reg_wdata[NB-1:0];
            if (w_wr && bus.reg_addr == 3'd3) r_gie <= bus.reg_wdata[1];
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus.reg_addr)
            3'd0: w_rd_mux[NB-1:0] = r_pend;
            3'd1: w_rd_mux[NB-1:0] = r_en;
            3'd2: w_rd_mux[4:0]    = r_cause;
            3'd3: w_rd_mux[1:0]    = {r_gie, r_busy};
`ifdef INTC_TIMER_EN
            3'd4: w_rd_mux         = r_mtime;
            3'd5: w_rd_mux         = r_mtimecmp;
`endif
            default: w_rd_mux      = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_rdata <= '0;
        else if (w_rd) r_rdata <= w_rd_mux;
    end

    // Request FSM. Leaving SERVICE always passes through IDLE, so intrpt_vld
    // is low for at least one cycle before every new request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_cause <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_gie && |w_act) begin
                        r_state <= ST_REQ;
                        r_vld   <= 1'b1;
                        r_cause <= w_win;
                    end
                end
                // Committed: only intrpt_taken leaves REQ; mask changes and
                // EOI writes have no effect here.
                ST_REQ: begin
                    if (bus.intrpt_taken) begin
                        r_state <= ST_SERVICE;
                        r_vld   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (w_eoi) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_vld   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.reg_rdata    = r_rdata;
    assign bus.intrpt_vld   = r_vld;
    assign bus.intrpt_cause = r_cause;
    assign bus.intrpt_busy  = r_busy;

endmodule

// File: tb/tb_otter_intrpt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_otter_intrpt_ctrl
// Directed bench for otter_intrpt_ctrl: a table of register accesses with
// hand-computed read values, followed by hand-written multi-cycle sequences
// for request latency, priority, masking, conflicts and async reset.
// ---------------------------------------------------------------------------
module tb_otter_intrpt_ctrl;
    localparam int NUM_SRC = 8;
    localparam int SYNC    = 2;

    logic               clk;
    logic               rst_n;
    logic [NUM_SRC-1:0] irq_src;

    int n_cmp  = 0;
    int n_fail = 0;

    otter_intrpt_ctrl_if bus();

    otter_intrpt_ctrl #(
        .NUM_SRC     (NUM_SRC),
        .SYNC_STAGES (SYNC)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_irq_src (irq_src),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
        bus.reg_sel   = 1'b1;
        bus.reg_we    = 1'b1;
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        tick();
        bus.reg_sel   = 1'b0;
        bus.reg_we    = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
        bus.reg_sel  = 1'b1;
        bus.reg_we   = 1'b0;
        bus.reg_addr = a;
        tick();
        bus.reg_sel  = 1'b0;
        d = bus.reg_rdata;
    endtask

    task automatic pulse_taken();
        bus.intrpt_taken = 1'b1;
        tick();
        bus.intrpt_taken = 1'b0;
    endtask

    task automatic wait_vld(input int max_cyc, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.intrpt_vld === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    vec_t        tbl [11];
    logic [31:0] rd;
    bit          found;

    initial begin
        tbl[0]  = '{"en_wr_a5",     1'b1, 3'd1, 32'h0000_00A5, 32'h0};
        tbl[1]  = '{"en_rd_a5",     1'b0, 3'd1, 32'h0,         32'h0000_00A5};
        tbl[2]  = '{"en_wr_wide",   1'b1, 3'd1, 32'hFFFF_FF5A, 32'h0};
        tbl[3]  = '{"en_rd_trunc",  1'b0, 3'd1, 32'h0,         32'h0000_005A};
        tbl[4]  = '{"status_rd0",   1'b0, 3'd3, 32'h0,         32'h0};
        tbl[5]  = '{"gie_wr",       1'b1, 3'd3, 32'h0000_0002, 32'h0};
        tbl[6]  = '{"status_gie",   1'b0, 3'd3, 32'h0,         32'h0000_0002};
        tbl[7]  = '{"addr7_wr",     1'b1, 3'd7, 32'hDEAD_BEEF, 32'h0};
        tbl[8]  = '{"addr7_rd",     1'b0, 3'd7, 32'h0,         32'h0};
        tbl[9]  = '{"claim_rd0",    1'b0, 3'd2, 32'h0,         32'h0};
        tbl[10] = '{"pend_rd0",     1'b0, 3'd0, 32'h0,         32'h0};

        rst_n            = 1'b0;
        irq_src          = '0;
        bus.reg_sel      = 1'b0;
        bus.reg_we       = 1'b0;
        bus.reg_addr     = '0;
        bus.reg_wdata    = '0;
        bus.intrpt_taken = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_vld",   {31'b0, bus.intrpt_vld},  32'h0);
        check("rst_cause", {27'b0, bus.intrpt_cause}, 32'h0);
        check("rst_busy",  {31'b0, bus.intrpt_busy}, 32'h0);
        check("rst_rdata", bus.reg_rdata,             32'h0);

        // Register table
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].we) begin
                reg_wr(tbl[i].addr, tbl[i].wdata);
            end else begin
                reg_rd(tbl[i].addr, rd);
                check(tbl[i].name, rd, tbl[i].exp);
            end
        end

        // Basic request latency: ENABLE=1, GIE=1, edge on src 0
        reg_wr(3'd1, 32'h1);
        reg_wr(3'd3, 32'h2);
        irq_src[0] = 1'b1;
        repeat (SYNC + 1) tick();
        check("lat_vld_early", {31'b0, bus.intrpt_vld}, 32'h0);
        tick();
        check("lat_vld",   {31'b0, bus.intrpt_vld},  32'h1);
        check("lat_cause", {27'b0, bus.intrpt_cause}, 32'h0);
        irq_src[0] = 1'b0;
        pulse_taken();
        check("taken_vld",  {31'b0, bus.intrpt_vld},  32'h0);
        check("taken_busy", {31'b0, bus.intrpt_busy}, 32'h1);
        reg_rd(3'd0, rd);
        check("taken_pend", rd, 32'h0);
        reg_rd(3'd3, rd);
        check("svc_status", rd, 32'h3);
        reg_wr(3'd2, 32'h0);
        check("eoi_busy", {31'b0, bus.intrpt_busy}, 32'h0);

        // Priority: PENDING 0x0C with ENABLE 0xFF
        reg_wr(3'd3, 32'h0);
        reg_wr(3'd1, 32'hFF);
        irq_src[2] = 1'b1;
        irq_src[3] = 1'b1;
        repeat (5) tick();
        reg_rd(3'd0, rd);
        check("prio_pend", rd, 32'h0C);
        reg_wr(3'd3, 32'h2);
        tick();
        check("prio_vld1",   {31'b0, bus.intrpt_vld},  32'h1);
        check("prio_cause1", {27'b0, bus.intrpt_cause}, 32'h2);
        pulse_taken();
        reg_wr(3'd2, 32'h0);
        check("prio_gap", {31'b0, bus.intrpt_vld}, 32'h0);
        tick();
        check("prio_vld2",   {31'b0, bus.intrpt_vld},  32'h1);
        check("prio_cause2", {27'b0, bus.intrpt_cause}, 32'h3);
        pulse_taken();
        reg_wr(3'd2, 32'h0);
        irq_src[2] = 1'b0;
        irq_src[3] = 1'b0;

        // Masking: src 5 pends with ENABLE=0, fires once enabled
        reg_wr(3'd1, 32'h0);
        irq_src[5] = 1'b1;
        repeat (5) tick();
        check("mask_vld", {31'b0, bus.intrpt_vld}, 32'h0);
        reg_rd(3'd0, rd);
        check("mask_pend", rd, 32'h20);
        reg_wr(3'd1, 32'h20);
        tick();
        check("mask_vld1",  {31'b0, bus.intrpt_vld},  32'h1);
        check("mask_cause", {27'b0, bus.intrpt_cause}, 32'h5);

        // Committed request: EOI and mask changes during REQ are ignored
        reg_wr(3'd2, 32'h0);
        check("req_eoi_vld", {31'b0, bus.intrpt_vld}, 32'h1);
        reg_rd(3'd3, rd);
        check("req_eoi_status", rd, 32'h2);
        reg_wr(3'd1, 32'h0);
        reg_wr(3'd3, 32'h0);
        tick();
        check("req_commit_vld",   {31'b0, bus.intrpt_vld},  32'h1);
        check("req_commit_cause", {27'b0, bus.intrpt_cause}, 32'h5);
        pulse_taken();
        check("req_commit_busy", {31'b0, bus.intrpt_busy}, 32'h1);
        reg_wr(3'd2, 32'h0);

        // intrpt_taken outside REQ is ignored
        pulse_taken();
        check("stray_taken_busy", {31'b0, bus.intrpt_busy}, 32'h0);
        check("stray_taken_vld",  {31'b0, bus.intrpt_vld},  32'h0);

        // Same-cycle W1C and new edge on src 1: set wins
        irq_src[1] = 1'b1;
        repeat (5) tick();
        irq_src[1] = 1'b0;
        repeat (5) tick();
        reg_rd(3'd0, rd);
        check("w1c_pre", rd, 32'h02);
        irq_src[1] = 1'b1;
        repeat (SYNC) tick();
        reg_wr(3'd0, 32'h02);
        reg_rd(3'd0, rd);
        check("w1c_conflict", rd, 32'h02);
        reg_wr(3'd0, 32'h02);
        reg_rd(3'd0, rd);
        check("w1c_plain", rd, 32'h0);
        irq_src[1] = 1'b0;
        irq_src[5] = 1'b0;

        // Async reset during REQ
        reg_wr(3'd1, 32'h10);
        reg_wr(3'd3, 32'h2);
        irq_src[4] = 1'b1;
        wait_vld(12, found);
        check("arst_reached_req", {31'b0, found},       32'h1);
        check("arst_cause",       {27'b0, bus.intrpt_cause}, 32'h4);
        #2;
        rst_n   = 1'b0;
        irq_src = '0;
        #1;
        check("arst_vld_async", {31'b0, bus.intrpt_vld}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst_rdata", bus.reg_rdata, 32'h0);
        reg_rd(3'd0, rd);
        check("arst_pend", rd, 32'h0);
        reg_rd(3'd1, rd);
        check("arst_en", rd, 32'h0);
        reg_rd(3'd3, rd);
        check("arst_status", rd, 32'h0);

`ifdef INTC_TIMER_EN
        // Timer source at index NUM_SRC
        reg_wr(3'd1, 32'h100);
        reg_wr(3'd5, 32'h20);
        reg_wr(3'd4, 32'h10);
        reg_wr(3'd3, 32'h2);
        wait_vld(40, found);
        check("timer_vld",   {31'b0, found},             32'h1);
        check("timer_cause", {27'b0, bus.intrpt_cause},  32'h8);
`else
        // Timer addresses are inert without the timer
        reg_wr(3'd4, 32'h1234_5678);
        reg_rd(3'd4, rd);
        check("mtime_absent", rd, 32'h0);
        reg_rd(3'd5, rd);
        check("mtimecmp_absent", rd, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
